// File: rtl/fpadd_stim_pkg.sv
// fpadd_stim_pkg: FSM states, vector count and operand ROMs for fpadd_stimulus.
// The expected-sum ROM exists only when FPADD_STIM_CHECK_EN is defined.
package fpadd_stim_pkg;
    localparam int NUM_VECS = 8;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;
    localparam logic [31:0] ROM_A [NUM_VECS] = '{
        32'h2ac49214, 32'h3f800000, 32'h41200000, 32'h3f800000,
        32'h3fc00000, 32'h00000000, 32'h40490fdb, 32'h40000000
    };
    localparam logic [31:0] ROM_B [NUM_VECS] = '{
        32'h6ac49214, 32'h3f800000, 32'h41a00000, 32'hbf000000,
        32'h3fc00000, 32'h3f800000, 32'h00000000, 32'hc0000000
    };
`ifdef FPADD_STIM_CHECK_EN
    localparam logic [31:0] ROM_EXP [NUM_VECS] = '{
        32'h6ac49214, 32'h40000000, 32'h41f00000, 32'h3f000000,
        32'h40400000, 32'h3f800000, 32'h40490fdb, 32'h00000000
    };
`endif
endpackage

// File: rtl/level_debouncer.sv
// level_debouncer: 2-FF synchronizer, stable-count debouncer and rising-edge press pulse.
module level_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic noisy_level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic sync1_q, sync1_d, sync2_q, sync2_d, level_q, level_d, prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic differ, done;
    always_comb begin
        differ  = sync2_q != level_q;
        done    = differ && cnt_q == CW'(DEBOUNCE_CYCLES);
        sync1_d = noisy_level;
        sync2_d = sync1_q;
        prev_d  = level_q;
        level_d = done ? sync2_q : level_q;
        cnt_d   = (!differ || done) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end
    assign press = level_q & ~prev_q;
endmodule

// File: rtl/fpadd_stimulus.sv
// fpadd_stimulus: steps a ROM of operand pairs into the FP adder on each button press and holds the sum.
// Optional FPADD_STIM_CHECK_EN adds the expected-value comparator driving check_fail.
module fpadd_stimulus
    import fpadd_stim_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PIPE_LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        noisy_level,
    input  logic [31:0] fp_result,
    output logic [31:0] reg_A,
    output logic [31:0] reg_B,
    output logic [2:0]  vec_index,
    output logic [31:0] result_out,
    output logic        result_valid,
    output logic        check_fail
);
    localparam int WW = $clog2(PIPE_LATENCY + 1);
    logic press;
    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic valid_q, valid_d;
    logic [WW-1:0] wcnt_q, wcnt_d;

    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk(clk), .rst(rst), .noisy_level(noisy_level), .press(press)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        valid_d = valid_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            LOAD: begin
                a_d     = ROM_A[idx_q];
                b_d     = ROM_B[idx_q];
                wcnt_d  = '0;
                state_d = WAIT;
            end
            // leaves one cycle beyond the adder latency before capturing
            WAIT: begin
                wcnt_d  = wcnt_q + 1'b1;
                state_d = wcnt_q == WW'(PIPE_LATENCY) ? CAPTURE : WAIT;
            end
            CAPTURE: begin
                res_d   = fp_result;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                idx_d   = press ? idx_q + 3'd1 : idx_q;
                valid_d = press ? 1'b0 : valid_q;
                state_d = press ? LOAD : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef FPADD_STIM_CHECK_EN
    logic fail_q, fail_d;
    always_comb
        fail_d = state_q == CAPTURE ? fp_result != ROM_EXP[idx_q]
               : (state_q == IDLE && press) ? 1'b0 : fail_q;
    always_ff @(posedge clk) fail_q <= rst ? 1'b0 : fail_d;
    assign check_fail = fail_q;
`else
    assign check_fail = 1'b0;
`endif

    assign reg_A        = a_q;
    assign reg_B        = b_q;
    assign vec_index    = idx_q;
    assign result_out   = res_q;
    assign result_valid = valid_q;
endmodule

// File: tb/tb_fpadd_stimulus.sv
// tb_fpadd_stimulus: timeline model of the sequencer checked every cycle, plus directed literal checks.
module tb_fpadd_stimulus;
    localparam int D = 4;
    localparam int P = 3;
`ifdef FPADD_STIM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [31:0] TA [8] = '{32'h2ac49214, 32'h3f800000, 32'h41200000, 32'h3f800000,
                                       32'h3fc00000, 32'h00000000, 32'h40490fdb, 32'h40000000};
    localparam logic [31:0] TB [8] = '{32'h6ac49214, 32'h3f800000, 32'h41a00000, 32'hbf000000,
                                       32'h3fc00000, 32'h3f800000, 32'h00000000, 32'hc0000000};
    localparam logic [31:0] TE [8] = '{32'h6ac49214, 32'h40000000, 32'h41f00000, 32'h3f000000,
                                       32'h40400000, 32'h3f800000, 32'h40490fdb, 32'h00000000};

    logic clk = 1'b0, rst = 1'b1, noisy = 1'b0, noisy2 = 1'b0, force_bad = 1'b0;
    logic [31:0] fp_result, reg_a, reg_b, result_out, fp_result2, reg_a2, reg_b2, result_out2;
    logic [2:0] vec_index, vec_index2;
    logic result_valid, check_fail, result_valid2, check_fail2;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fpadd_stimulus #(.DEBOUNCE_CYCLES(D), .PIPE_LATENCY(P)) dut (
        .clk(clk), .rst(rst), .noisy_level(noisy), .fp_result(fp_result),
        .reg_A(reg_a), .reg_B(reg_b), .vec_index(vec_index), .result_out(result_out),
        .result_valid(result_valid), .check_fail(check_fail)
    );
    // long adder wait so a second press can land inside WAIT despite debouncing
    fpadd_stimulus #(.DEBOUNCE_CYCLES(2), .PIPE_LATENCY(20)) dut2 (
        .clk(clk), .rst(rst), .noisy_level(noisy2), .fp_result(fp_result2),
        .reg_A(reg_a2), .reg_B(reg_b2), .vec_index(vec_index2), .result_out(result_out2),
        .result_valid(result_valid2), .check_fail(check_fail2)
    );

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h2ac49214, 32'h6ac49214}: return 32'h6ac49214;
            {32'h3f800000, 32'h3f800000}: return 32'h40000000;
            {32'h41200000, 32'h41a00000}: return 32'h41f00000;
            {32'h3f800000, 32'hbf000000}: return 32'h3f000000;
            {32'h3fc00000, 32'h3fc00000}: return 32'h40400000;
            {32'h00000000, 32'h3f800000}: return 32'h3f800000;
            {32'h40490fdb, 32'h00000000}: return 32'h40490fdb;
            {32'h40000000, 32'hc0000000}: return 32'h00000000;
            {32'h00000000, 32'h00000000}: return 32'h00000000;
            default: return 32'hdeadbeef;
        endcase
    endfunction

    function automatic logic [31:0] adder(input logic [31:0] a, input logic [31:0] b, input logic bad);
        return (bad && a == 32'h3f800000 && b == 32'h3f800000) ? 32'h00000001 : fadd(a, b);
    endfunction

    logic [31:0] p1, p2, p3, q1, q2, q3;
    always @(posedge clk) begin
        p1 <= adder(reg_a, reg_b, force_bad);
        p2 <= p1;
        p3 <= p2;
        q1 <= fadd(reg_a2, reg_b2);
        q2 <= q1;
        q3 <= q2;
    end
    assign fp_result  = p3;
    assign fp_result2 = q3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: events are scheduled by edge number rather than by FSM state.
    int cyc = 0, load_at = 0, cap_at = -1, run = 0;
    bit s1, s2, db, dbp, idle, pr, started = 0;
    logic [2:0] m_idx;
    logic [31:0] m_a, m_b, m_res;
    bit m_valid, m_fail;
    always @(posedge clk) begin
        pr = db && !dbp;
        cyc++;
        started = 1;
        if (rst) begin
            m_idx = 0; m_a = 0; m_b = 0; m_res = 0; m_valid = 0; m_fail = 0;
            idle = 0; load_at = cyc + 1; cap_at = -1;
            s1 = 0; s2 = 0; db = 0; dbp = 0; run = 0;
        end else begin
            if (cyc == load_at) begin
                m_a = TA[m_idx];
                m_b = TB[m_idx];
                cap_at = cyc + P + 2;
            end
            if (cyc == cap_at) begin
                m_res = adder(m_a, m_b, force_bad);
                m_valid = 1;
                m_fail = CHK && m_res != TE[m_idx];
                idle = 1;
            end else if (idle && pr) begin
                m_idx++;
                m_valid = 0;
                m_fail = 0;
                idle = 0;
                load_at = cyc + 1;
            end
            dbp = db;
            if (s2 != db) begin
                run++;
                if (run == D + 1) begin
                    db = s2;
                    run = 0;
                end
            end else run = 0;
            s2 = s1;
            s1 = noisy;
        end
    end

    always @(negedge clk) if (started) begin
        chk("model vec_index", {29'd0, vec_index}, {29'd0, m_idx});
        chk("model reg_A", reg_a, m_a);
        chk("model reg_B", reg_b, m_b);
        chk("model result_out", result_out, m_res);
        chk("model result_valid", {31'd0, result_valid}, {31'd0, m_valid});
        chk("model check_fail", {31'd0, check_fail}, {31'd0, m_fail});
    end

    task automatic press();
        noisy = 1'b1;
        repeat (12) @(negedge clk);
        noisy = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("reset vec_index", {29'd0, vec_index}, 32'd0);
        chk("reset reg_A", reg_a, 32'h0);
        chk("reset result_valid", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("vec0 not yet valid at LOAD+4", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        chk("vec0 valid at LOAD+5", {31'd0, result_valid}, 32'd1);
        chk("vec0 result", result_out, 32'h6ac49214);
        chk("vec0 reg_A", reg_a, 32'h2ac49214);
        repeat (4) @(negedge clk);
        noisy = 1'b1;
        repeat (7) @(negedge clk);
        chk("press not yet taken", {29'd0, vec_index}, 32'd0);
        @(negedge clk);
        chk("press index", {29'd0, vec_index}, 32'd1);
        chk("press drops valid", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        chk("vec1 reg_A", reg_a, 32'h3f800000);
        chk("vec1 reg_B", reg_b, 32'h3f800000);
        repeat (5) @(negedge clk);
        chk("vec1 result", result_out, 32'h40000000);
        chk("vec1 valid", {31'd0, result_valid}, 32'd1);
        noisy = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            noisy = 1'b1;
            repeat (3) @(negedge clk);
            noisy = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("glitches ignored", {29'd0, vec_index}, 32'd1);
        for (int i = 0; i < 6; i++) press();
        chk("index reaches 7", {29'd0, vec_index}, 32'd7);
        chk("vec7 result", result_out, 32'h00000000);
        press();
        chk("index wraps", {29'd0, vec_index}, 32'd0);
        chk("wrap result", result_out, 32'h6ac49214);
        noisy2 = 1'b1;
        repeat (8) @(negedge clk);
        noisy2 = 1'b0;
        repeat (8) @(negedge clk);
        noisy2 = 1'b1;
        repeat (8) @(negedge clk);
        chk("second press dropped", {29'd0, vec_index2}, 32'd1);
        chk("still waiting", {31'd0, result_valid2}, 32'd0);
        noisy2 = 1'b0;
        repeat (30) @(negedge clk);
        chk("single increment", {29'd0, vec_index2}, 32'd1);
        chk("slow vec1 result", result_out2, 32'h40000000);
        chk("slow vec1 valid", {31'd0, result_valid2}, 32'd1);
        press();
        press();
        noisy = 1'b1;
        repeat (10) @(negedge clk);
        chk("vec3 loaded", reg_b, 32'hbf000000);
        rst = 1'b1;
        noisy = 1'b0;
        @(negedge clk);
        chk("abort vec_index", {29'd0, vec_index}, 32'd0);
        chk("abort reg_A", reg_a, 32'h0);
        chk("abort reg_B", reg_b, 32'h0);
        chk("abort result", result_out, 32'h0);
        chk("abort valid", {31'd0, result_valid}, 32'd0);
        chk("abort check_fail", {31'd0, check_fail}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("restart result", result_out, 32'h6ac49214);
        chk("restart valid", {31'd0, result_valid}, 32'd1);
        force_bad = 1'b1;
        press();
        chk("bad vec1 result", result_out, 32'h00000001);
        chk("bad vec1 check_fail", {31'd0, check_fail}, {31'd0, CHK});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
